// File: rtl/wb_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// wb_stage_skid_reg
// MEM->WB pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer. The main entry drives the W-side outputs and the
// skid entry absorbs one payload when WB stalls. in_ready is taken straight
// from the state flop, so out_ready never reaches in_ready combinationally.
// Optional feature macro: WB_STALL_CNT_EN adds a 32-bit stall_cnt output that
// counts cycles with out_valid & !out_ready (cleared by rst only).
// ---------------------------------------------------------------------------
module wb_stage_skid_reg #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int RES_SRC_W      = 2,
    parameter bit ZERO_REG_GUARD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       ALUResultM,
    input  logic [XLEN-1:0]       ReadData,
    input  logic [XLEN-1:0]       PCPlus4M,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [RES_SRC_W-1:0]  ResultSrcM,
    input  logic                  RegWriteM,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       ALUResultW,
    output logic [XLEN-1:0]       ReadDataW,
    output logic [XLEN-1:0]       PCPlus4W,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [RES_SRC_W-1:0]  ResultSrcW,
`ifdef WB_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  RegWriteW
);

    typedef struct packed {
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       rdata;
        logic [XLEN-1:0]       pc4;
        logic [REG_ADDR_W-1:0] rd;
        logic [RES_SRC_W-1:0]  src;
        logic                  rw;
    } payload_t;

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable and recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t   state_r;
    payload_t main_r;
    payload_t skid_r;
    payload_t in_payload_s;
    logic     main_v_s;
    logic     in_ready_s;
    logic     in_fire_s;
    logic     out_fire_s;
    logic     zero_rd_blk_s;

    assign in_payload_s = '{alu: ALUResultM, rdata: ReadData, pc4: PCPlus4M,
                            rd: RdM, src: ResultSrcM, rw: RegWriteM};

    assign main_v_s   = (state_r == ST_ONE) || (state_r == ST_FULL);
    assign in_ready_s = (state_r != ST_FULL);
    assign in_fire_s  = in_valid & in_ready_s & ~flush;
    assign out_fire_s = main_v_s & out_ready;

    // State and payload storage: reset beats flush, flush beats any fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            main_r  <= '0;
            skid_r  <= '0;
        end else if (flush) begin
            // Payload flops keep their contents; only the valid bits drop.
            state_r <= ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_r  <= in_payload_s;
                        state_r <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_r <= in_payload_s;
                    end else if (in_fire_s) begin
                        skid_r  <= in_payload_s;
                        state_r <= ST_FULL;
                    end else if (out_fire_s) begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // The skid entry is older than anything upstream, so it
                    // always moves into main before new input is taken.
                    if (out_fire_s) begin
                        main_r  <= skid_r;
                        state_r <= ST_ONE;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    assign zero_rd_blk_s = ZERO_REG_GUARD && (main_r.rd == {REG_ADDR_W{1'b0}});

    assign in_ready   = in_ready_s;
    assign out_valid  = main_v_s;
    assign ALUResultW = main_r.alu;
    assign ReadDataW  = main_r.rdata;
    assign PCPlus4W   = main_r.pc4;
    assign RdW        = main_r.rd;
    assign ResultSrcW = main_r.src;
    assign RegWriteW  = main_r.rw & main_v_s & ~zero_rd_blk_s;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Count WB back-pressure cycles; wraps naturally, flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (main_v_s && !out_ready) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/wb_stage_skid_reg.md
Name: wb_stage_skid_reg

Overview:
- Parametrised MEM->WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Lets the writeback side stall without combinational back-pressure reaching the MEM stage. Adds flush and write-enable gating.
- Sits between the data-memory stage and the register-file writeback mux. Carries ALU result, load data, PC+4, destination register, result-select and register-write enable.

Parameters:
- XLEN, 32, width of the ALUResult/ReadData/PCPlus4 fields
- REG_ADDR_W, 5, width of the destination register index
- RES_SRC_W, 2, width of the result-select field
- ZERO_REG_GUARD, 1, when 1, RegWriteW is suppressed if RdW == 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  MEM-side payload valid
- in_ready  out  1  stage can accept a payload (registered)
- ALUResultM  in  XLEN  ALU result
- ReadData  in  XLEN  load data
- PCPlus4M  in  XLEN  PC+4
- RdM  in  REG_ADDR_W  destination register
- ResultSrcM  in  RES_SRC_W  result-select
- RegWriteM  in  1  register write enable
- out_valid  out  1  WB-side payload valid
- out_ready  in  1  WB side consumes payload
- ALUResultW, ReadDataW, PCPlus4W  out  XLEN  registered payload
- RdW  out  REG_ADDR_W  registered destination
- ResultSrcW  out  RES_SRC_W  registered result-select
- RegWriteW  out  1  gated write enable

Behaviour:
- Fire rules: in_fire = in_valid & in_ready & !flush; out_fire = out_valid & out_ready.
- Storage: main entry drives the outputs; skid entry holds one overflow payload.
- States, encoded by {skid_v, main_v}:
  - EMPTY: in_ready=1, out_valid=0
  - ONE: in_ready=1, out_valid=1
  - FULL: in_ready=0, out_valid=1
- Transitions:
  - EMPTY: in_fire -> ONE, payload into main.
  - ONE: in_fire & out_fire -> ONE, main replaced.
  - ONE: in_fire & !out_fire -> FULL, payload into skid.
  - ONE: !in_fire & out_fire -> EMPTY.
  - ONE: neither fire -> hold.
  - FULL: out_fire -> ONE, skid copied to main. No input accepted.
  - FULL: otherwise hold.
- in_ready = !skid_v, driven from a flop, so there is no combinational path from out_ready to in_ready.
- Latency: payload accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1. Throughput is 1/cycle while out_ready=1.
- Ordering: strict FIFO. The skid entry is never overtaken.
- RegWriteW = main.RegWrite & main_v & !(ZERO_REG_GUARD & (RdW==0)).
- Reset (rst=1 at an edge):
  - State goes to EMPTY.
  - All payload flops go to 0; outputs read ALUResultW=ReadDataW=PCPlus4W=0, RdW=0, ResultSrcW=0, RegWriteW=0, out_valid=0, in_ready=1.
  - Reset overrides flush and any fire, including mid-FULL.
- Flush (rst=0, flush=1):
  - Next state is EMPTY; both valid bits clear.
  - Payload flops hold their old values, but RegWriteW reads 0 because main_v=0.
  - An in_valid in the same cycle is discarded; upstream treats it as killed.
  - An out_fire in the same cycle still counts as consumed.
- Payload flops load only on their own write enable. Holding with no fire leaves every output stable.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits).
  - Increments on every cycle with out_valid & !out_ready and wraps at 2^32-1 -> 0.
  - Cleared by rst; not affected by flush.
- Undefined: no port and no counter logic.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all W outputs 0.
- Streaming: out_ready=1; push ALUResultM=0x10,0x20,0x30 on back-to-back cycles -> the same values appear on ALUResultW one cycle later each, and in_ready stays 1.
- Skid: push A=0x11, then drop out_ready for the cycle B=0x22 arrives -> in_ready=0 next cycle. Raise out_ready -> outputs A then B, nothing lost, then in_ready=1.
- Flush in FULL: in state FULL, assert flush together with in_valid (C=0x33) -> next cycle out_valid=0, RegWriteW=0, C never appears.
- Zero-reg guard: push RdM=0, RegWriteM=1 -> RegWriteW=0 while out_valid=1. Push RdM=5 -> RegWriteW=1.
- WB_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles -> stall_cnt=7. Then flush -> stall_cnt stays 7. Then rst -> 0.
